// File: rtl/aes_inv_arb_pkg.sv
// Shared types and constants for the AES inverse-cipher job scheduler.
package aes_inv_arb_pkg;

    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned CORE_LAT  = 12;

    typedef enum logic [2:0] {IDLE, KEY, KWAIT, LOAD, RUN, RESP} arb_state_t;

endpackage

// File: rtl/aes_inv_arb_rr_arbiter.sv
// Rotating-priority arbiter: the search starts at the pointer, and the pointer
// moves past the winner only when the caller accepts the grant.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int unsigned IdxW = $clog2(N);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] cand;

    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IdxW'(s);
    endfunction

    // Scan from farthest to nearest offset so the closest requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = wrap_add(ptr_q, unsigned'(i));
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = wrap_add(gnt_idx, 1);
    end

    always_ff @(posedge clk) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/aes_inv_arb.sv
// Shares one AES inverse-cipher core among NREQ requesters: arbitrates jobs,
// skips the key reload on a cache hit, sequences kld/ld and returns plaintext.
module aes_inv_arb
    import aes_inv_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned KEY_WAIT = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*AES_BLK_W-1:0]   req_key,
    input  logic [NREQ*AES_BLK_W-1:0]   req_text,
    output logic [NREQ-1:0]             rsp_valid,
    input  logic [NREQ-1:0]             rsp_ready,
    output logic [AES_BLK_W-1:0]        rsp_data,
    output logic                        core_kld,
    output logic                        core_ld,
    output logic [AES_BLK_W-1:0]        core_key,
    output logic [AES_BLK_W-1:0]        core_text_in,
    input  logic                        core_done,
    input  logic [AES_BLK_W-1:0]        core_text_out
);

    localparam int unsigned IdxW = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(KEY_WAIT);
    localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

    arb_state_t            state_q, state_d;
    logic [AES_BLK_W-1:0]  job_key_q, job_key_d;
    logic [AES_BLK_W-1:0]  job_text_q, job_text_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [AES_BLK_W-1:0]  key_cache_q, key_cache_d;
    logic                  key_vld_q, key_vld_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [AES_BLK_W-1:0]  rsp_data_q, rsp_data_d;
    logic                  core_kld_q, core_kld_d;
    logic                  core_ld_q, core_ld_d;

    logic [NREQ-1:0]       gnt;
    logic [IdxW-1:0]       gnt_idx;
    logic                  accept;
    logic [AES_BLK_W-1:0]  sel_key, sel_text;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Gated by rst so nothing is offered while the block is held in reset.
    assign accept    = (state_q == IDLE) && rst && (|gnt);
    assign req_ready = accept ? gnt : '0;

    always_comb begin
        sel_key  = '0;
        sel_text = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_key  = req_key[i*AES_BLK_W +: AES_BLK_W];
                sel_text = req_text[i*AES_BLK_W +: AES_BLK_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        job_key_d   = job_key_q;
        job_text_d  = job_text_q;
        owner_d     = owner_q;
        key_cache_d = key_cache_q;
        key_vld_d   = key_vld_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        core_kld_d  = 1'b0;
        core_ld_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    job_key_d  = sel_key;
                    job_text_d = sel_text;
                    owner_d    = gnt_idx;
                    if (key_vld_q && (sel_key == key_cache_q)) begin
                        state_d   = LOAD;
                        core_ld_d = 1'b1;
                    end else begin
                        state_d    = KEY;
                        core_kld_d = 1'b1;
                    end
                end
            end
            KEY: begin
                key_cache_d = job_key_q;
                key_vld_d   = 1'b0;
                cnt_d       = CntW'(KEY_WAIT - 1);
                state_d     = KWAIT;
            end
            KWAIT: begin
                if (cnt_q == '0) begin
                    key_vld_d = 1'b1;
                    core_ld_d = 1'b1;
                    state_d   = LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (core_done) begin
                    rsp_data_d  = core_text_out;
                    rsp_valid_d = OneHot0 << owner_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            job_key_q   <= '0;
            job_text_q  <= '0;
            owner_q     <= '0;
            key_cache_q <= '0;
            key_vld_q   <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            core_kld_q  <= 1'b0;
            core_ld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_key_q   <= job_key_d;
            job_text_q  <= job_text_d;
            owner_q     <= owner_d;
            key_cache_q <= key_cache_d;
            key_vld_q   <= key_vld_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            core_kld_q  <= core_kld_d;
            core_ld_q   <= core_ld_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign core_kld     = core_kld_q;
    assign core_ld      = core_ld_q;
    assign core_key     = job_key_q;
    assign core_text_in = job_text_q;

endmodule

// File: tb/tb_aes_inv_arb.sv
// Bench for aes_inv_arb: behavioural core model plus a response scoreboard.
module tb_aes_inv_arb;
    import aes_inv_arb_pkg::*;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned KEY_WAIT = 12;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NREQ-1:0]           req_valid = '0;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ*128-1:0]       req_key = '0;
    logic [NREQ*128-1:0]       req_text = '0;
    logic [NREQ-1:0]           rsp_valid;
    logic [NREQ-1:0]           rsp_ready = '1;
    logic [127:0]              rsp_data;
    logic                      core_kld, core_ld;
    logic [127:0]              core_key, core_text_in;
    logic                      core_done_m = 1'b0;
    logic                      spur = 1'b0;
    logic [127:0]              core_text_m = '0;
    logic                      core_done_w;
    logic [127:0]              core_text_w;

    assign core_done_w = core_done_m | spur;
    assign core_text_w = spur ? 128'hdeadbeef_deadbeef_deadbeef_deadbeef : core_text_m;

    aes_inv_arb #(
        .NREQ     (NREQ),
        .KEY_WAIT (KEY_WAIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_key       (req_key),
        .req_text      (req_text),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .core_kld      (core_kld),
        .core_ld       (core_ld),
        .core_key      (core_key),
        .core_text_in  (core_text_in),
        .core_done     (core_done_w),
        .core_text_out (core_text_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int viol = 0;
    int acc_cyc, kld_cyc, ld_cyc, rspv_cyc;
    int kld_cnt = 0;
    bit rspv_prev = 1'b0;

    typedef struct {
        int           idx;
        logic [127:0] pt;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int   grants[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Stand-in decryption: exact FIPS-197 vector, otherwise a key-dependent mix
    // so a stale core key gives a visibly different plaintext.
    function automatic logic [127:0] fake_dec(input logic [127:0] k, input logic [127:0] c);
        if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
        return c ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: latches the key on kld, returns the block CORE_LAT cycles after ld.
    logic [127:0] mk = '0;
    logic [127:0] mres = '0;
    bit           busy = 1'b0;
    bit           kld_seen = 1'b0;
    int           mcnt = 0;
    int           kld_m = 0;
    always @(posedge clk) begin
        core_done_m <= 1'b0;
        if (!rst) begin
            busy <= 1'b0;
        end else begin
            if (core_kld) begin
                mk       <= core_key;
                kld_m    <= cyc;
                kld_seen <= 1'b1;
            end
            if (core_ld) begin
                if (kld_seen && (cyc - kld_m) < int'(KEY_WAIT)) viol++;
                busy <= 1'b1;
                mcnt <= CORE_LAT - 1;
                mres <= fake_dec(mk, core_text_in);
            end else if (busy) begin
                if (mcnt == 1) begin
                    core_done_m <= 1'b1;
                    core_text_m <= mres;
                    busy        <= 1'b0;
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_cyc = cyc;
                    grants.push_back(i);
                    sb.push_back('{i, fake_dec(req_key[i*128 +: 128], req_text[i*128 +: 128])});
                end
            end
            if (core_kld) begin
                kld_cyc = cyc;
                kld_cnt++;
            end
            if (core_ld) ld_cyc = cyc;
            if (core_kld && core_ld) viol++;
            if (!$onehot0(req_ready) || !$onehot0(rsp_valid)) viol++;
            if (|rsp_valid && !rspv_prev) rspv_cyc = cyc;
            if (|(rsp_valid & rsp_ready)) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", 128'(rsp_valid), 128'(1) << e.idx);
                    chk("rsp_data", rsp_data, e.pt);
                end
            end
        end
        rspv_prev = |rsp_valid;
    end

    task automatic reset_and_check();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_data", rsp_data, 128'(0));
        chk("rst_core_kld", 128'(core_kld), 128'(0));
        chk("rst_core_ld", 128'(core_ld), 128'(0));
        chk("rst_core_key", core_key, 128'(0));
        chk("rst_core_text", core_text_in, 128'(0));
        @(posedge clk);
        #1 req_valid = '0;
        rst = 1'b1;
    endtask

    task automatic submit(input int idx, input logic [127:0] k, input logic [127:0] t);
        int n = 0;
        @(posedge clk);
        #1 req_valid[idx] = 1'b1;
        req_key[idx*128 +: 128]  = k;
        req_text[idx*128 +: 128] = t;
        @(negedge clk);
        while (!req_ready[idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 128'(req_ready[idx]), 128'(1));
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int k0, n, bad;
        logic [127:0] hold;
        logic [127:0] t2;

        // Reset with every requester offering: nothing may be accepted.
        req_valid = '1;
        reset_and_check();

        // FIPS-197 single job, key miss.
        submit(0, FIPS_KEY, FIPS_CT);
        drain(100);
        chk("miss_kld_lat", 128'(kld_cyc - acc_cyc), 128'(1));
        chk("miss_ld_lat", 128'(ld_cyc - acc_cyc), 128'(2 + KEY_WAIT));
        chk("miss_rsp_lat", 128'(rspv_cyc - acc_cyc), 128'(15 + KEY_WAIT));

        // Same job from requester 2: key cache hit.
        k0 = kld_cnt;
        submit(2, FIPS_KEY, FIPS_CT);
        drain(100);
        chk("hit_no_kld", 128'(kld_cnt - k0), 128'(0));
        chk("hit_ld_lat", 128'(ld_cyc - acc_cyc), 128'(1));
        chk("hit_rsp_lat", 128'(rspv_cyc - acc_cyc), 128'(14));

        // Done pulse while idle must be ignored.
        @(posedge clk);
        #1 spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("spur_rsp_data", rsp_data, FIPS_PT);

        // Round robin with all requesters valid from a fresh pointer.
        reset_and_check();
        grants.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_key[i*128 +: 128]  = FIPS_KEY;
            req_text[i*128 +: 128] = (i == 0) ? FIPS_CT : {4{$urandom}};
        end
        req_valid = '1;
        n = 0;
        while (grants.size() < 5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = '0;
        drain(100);
        chk("rr_count", 128'(grants.size()), 128'(5));
        for (int i = 0; i < grants.size() && i < 5; i++) chk("rr_order", 128'(grants[i]), 128'(i % 4));

        // Backpressure: owner bit low, other ready bits high, another job pending.
        rsp_ready = 4'b1011;
        t2 = {4{$urandom}};
        submit(2, FIPS_KEY, t2);
        @(posedge clk);
        #1 req_valid[0] = 1'b1;
        req_key[127:0]  = KEY_B;
        req_text[127:0] = {4{$urandom}};
        n = 0;
        while (!rsp_valid[2] && n < 100) begin
            @(negedge clk);
            n++;
        end
        hold = rsp_data;
        chk("bp_data", hold, fake_dec(FIPS_KEY, t2));
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0100 || rsp_data !== hold || req_ready !== 4'b0000) bad++;
        end
        chk("bp_stable", 128'(bad), 128'(0));
        @(posedge clk);
        #1 rsp_ready = '1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_next", 128'(req_ready), 128'(4'b0001));
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        drain(100);

        // Reset during RUN, then resubmit: key must reload.
        submit(1, FIPS_KEY, FIPS_CT);
        n = 0;
        while (!core_ld && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        reset_and_check();
        repeat (20) @(negedge clk);
        chk("rst_no_rsp", 128'(rsp_valid), 128'(0));
        k0 = kld_cnt;
        submit(1, FIPS_KEY, FIPS_CT);
        drain(100);
        chk("rst_reload_kld", 128'(kld_cnt - k0), 128'(1));

        // Alternating keys between requesters 0 and 1.
        k0 = kld_cnt;
        for (int j = 0; j < 4; j++) begin
            submit(j % 2, (j % 2 == 0) ? KEY_B : FIPS_KEY, {4{$urandom}});
            drain(100);
        end
        chk("keychg_kld", 128'(kld_cnt - k0), 128'(4));

        chk("protocol_viol", 128'(viol), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
